// File: rtl/pp_accumulator.sv
// rtl/pp_accumulator.sv - partial-product summation and framed signed accumulation
//
// Purpose:
//   Last stage of the split 27x18 signed multiplier. Stage 1 adds the two
//   45-bit partial products to form the exact product. Stage 2 adds each
//   product into a wide signed accumulator over a frame bounded by in_first
//   and in_last. One result per frame, 2 cycles after the last term.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears every register
//   pp1          low partial product (signed): a * zero-extended b[8:0]
//   pp2          high partial product (signed), already shifted left by 9
//   in_valid     pp1/pp2/in_first/in_last valid this cycle
//   in_first     term opens a new frame (qualified by in_valid)
//   in_last      term closes the frame (qualified by in_valid)
//   result       accumulated frame sum (signed)
//   result_valid single-cycle pulse, result/overflow/term_count valid
//   overflow     a signed overflow occurred somewhere in the frame
//   term_count   number of valid terms in the frame (saturating)

module pp_accumulator #(
  parameter int PP_W     = 45,
  parameter int ACC_W    = 48,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PP_W-1:0]  pp1,
  input  logic [PP_W-1:0]  pp2,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] term_count
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // One extra bit holds the exact sum of two PP_W-bit signed values.
  logic signed [PP_W:0]    pp_sum;

  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;
  logic signed [ACC_W-1:0] s1_sum;

  logic [ACC_W-1:0]        acc;
  logic                    sticky;
  logic [CNT_W-1:0]        cnt;

  logic [ACC_W-1:0]        base;
  logic [ACC_W-1:0]        raw_sum;
  logic                    add_ovf;
  logic [ACC_W-1:0]        acc_next;
  logic                    sticky_next;
  logic [CNT_W-1:0]        cnt_base;
  logic [CNT_W-1:0]        cnt_next;

  assign pp_sum = {pp1[PP_W-1], pp1} + {pp2[PP_W-1], pp2};

  always_comb begin
    base        = s1_first ? '0 : acc;
    cnt_base    = s1_first ? '0 : cnt;
    raw_sum     = base + s1_sum;
    // Same-sign operands producing a result of the opposite sign.
    add_ovf     = (base[ACC_W-1] == s1_sum[ACC_W-1]) &&
                  (raw_sum[ACC_W-1] != base[ACC_W-1]);
    acc_next    = raw_sum;
    if ((SATURATE != 0) && add_ovf) begin
      // Overflow direction follows the common operand sign.
      acc_next = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
    sticky_next = (s1_first ? 1'b0 : sticky) | add_ovf;
    cnt_next    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_sum       <= '0;
      acc          <= '0;
      sticky       <= 1'b0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      term_count   <= '0;
    end else begin
      s1_valid     <= in_valid;
      s1_first     <= in_valid & in_first;
      s1_last      <= in_valid & in_last;
      s1_sum       <= ACC_W'(pp_sum);
      result_valid <= 1'b0;
      if (s1_valid) begin
        acc    <= acc_next;
        sticky <= sticky_next;
        cnt    <= cnt_next;
        if (s1_last) begin
          result       <= acc_next;
          overflow     <= sticky_next;
          term_count   <= cnt_next;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
// tb/tb_pp_accumulator.sv - scoreboard bench for pp_accumulator (wrap and saturate instances)

module tb_pp_accumulator;

  typedef logic [115:0] pulse_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [44:0] pp1 = '0;
  logic signed [44:0] pp2 = '0;
  logic               in_valid = 1'b0;
  logic               in_first = 1'b0;
  logic               in_last = 1'b0;

  logic [47:0] r0, r1;
  logic        rv0, rv1, o0, o1;
  logic [7:0]  c0, c1;

  int     n_checks = 0;
  int     n_fail = 0;
  pulse_t exp_q[$];
  pulse_t obs_mem[64];
  int     obs_wr = 0;
  int     obs_rd = 0;

  always #5 clk = ~clk;

  pp_accumulator #(.PP_W(45), .ACC_W(48), .CNT_W(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .pp1(pp1), .pp2(pp2), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .result(r0), .result_valid(rv0),
    .overflow(o0), .term_count(c0)
  );

  pp_accumulator #(.PP_W(45), .ACC_W(48), .CNT_W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .pp1(pp1), .pp2(pp2), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .result(r1), .result_valid(rv1),
    .overflow(o1), .term_count(c1)
  );

  // Capture every output pulse of either instance for the scoreboard.
  always @(negedge clk) begin
    if ((rv0 || rv1) && obs_wr < 64) begin
      obs_mem[obs_wr] = {rv0, rv1, r0, o0, c0, r1, o1, c1};
      obs_wr = obs_wr + 1;
    end
  end

  task automatic term(input logic v, input logic f, input logic l,
                      input logic signed [44:0] p1, input logic signed [44:0] p2);
    in_valid = v; in_first = f; in_last = l; pp1 = p1; pp2 = p2;
    @(posedge clk); #1;
  endtask

  // Split a*b the way the upstream multiplier does.
  task automatic term_ab(input logic f, input logic l, input longint a, input longint b);
    longint p1, p2;
    p1 = a * (b & 511);
    p2 = (a * (b >>> 9)) * 512;
    term(1'b1, f, l, 45'(p1), 45'(p2));
  endtask

  task automatic term_v(input logic f, input logic l, input longint v);
    term(1'b1, f, l, 45'(v - 512), 45'(512));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) term(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic expect_frame(input logic [47:0] rw, input logic ow,
                              input logic [47:0] rs, input logic os, input logic [7:0] cnt);
    exp_q.push_back({2'b11, rw, ow, cnt, rs, os, cnt});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_checks++;
    if ({rv0, r0, o0, c0, rv1, r1, o1, c1} !== 116'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", {rv0, r0, o0, c0, rv1, r1, o1, c1});
    end
    reset = 1'b0;
    idle(2);
    n_checks++;
    if (obs_wr != 0) begin
      n_fail++;
      $display("FAIL reset_no_pulse got=%0d pulses want=0", obs_wr);
    end
    obs_rd = obs_wr;
  endtask

  task automatic test_single_and_sign;
    pulse_t e;
    term_ab(1, 1, 3, 5);
    expect_frame(48'd15, 0, 48'd15, 0, 8'd1);
    idle(1);
    term_ab(1, 1, -2, -1);
    expect_frame(48'd2, 0, 48'd2, 0, 8'd1);
    term_v(1, 0, 100);
    term_v(0, 0, -250);
    term_v(0, 1, 7);
    expect_frame(-48'sd143, 0, -48'sd143, 0, 8'd3);
    idle(4);
    while (obs_rd < obs_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL single_sign stray got=%h want=no pulse", obs_mem[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin
          n_fail++;
          $display("FAIL single_sign got=%h want=%h", obs_mem[obs_rd], e);
        end
      end
      obs_rd++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_sign missing got=0 want=%0d more pulses", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    pulse_t e;
    term_v(1, 0, 10);
    term(1'b0, 1'b0, 1'b1, 45'sd999, 45'sd0);   // in_last without in_valid
    term(1'b0, 1'b0, 1'b0, '0, '0);
    term_v(0, 1, 20);
    expect_frame(48'd30, 0, 48'd30, 0, 8'd2);
    term_v(1, 0, 1);
    term_v(0, 0, 1);
    term_v(0, 1, 1);
    expect_frame(48'd3, 0, 48'd3, 0, 8'd3);
    idle(4);
    while (obs_rd < obs_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL back_to_back stray got=%h want=no pulse", obs_mem[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin
          n_fail++;
          $display("FAIL back_to_back got=%h want=%h", obs_mem[obs_rd], e);
        end
      end
      obs_rd++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back missing got=0 want=%0d more pulses", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_overflow;
    pulse_t e;
    for (int i = 0; i < 16; i++) term_ab(i == 0, i == 15, -(64'sd1 <<< 26), -(64'sd1 <<< 17));
    expect_frame(48'h8000_0000_0000, 1, 48'h7FFF_FFFF_FFFF, 1, 8'd16);
    for (int i = 0; i < 15; i++) term_ab(i == 0, i == 14, -(64'sd1 <<< 26), -(64'sd1 <<< 17));
    expect_frame(48'h7800_0000_0000, 0, 48'h7800_0000_0000, 0, 8'd15);
    for (int i = 0; i < 16; i++) term_ab(i == 0, 0, -(64'sd1 <<< 26), -(64'sd1 <<< 17));
    term_ab(0, 1, -1, 1);
    expect_frame(48'h7FFF_FFFF_FFFF, 1, 48'h7FFF_FFFF_FFFE, 1, 8'd17);
    term_ab(1, 1, 3, 5);
    expect_frame(48'd15, 0, 48'd15, 0, 8'd1);
    idle(4);
    while (obs_rd < obs_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL overflow stray got=%h want=no pulse", obs_mem[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin
          n_fail++;
          $display("FAIL overflow got=%h want=%h", obs_mem[obs_rd], e);
        end
      end
      obs_rd++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL overflow missing got=0 want=%0d more pulses", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_count_saturation;
    pulse_t e;
    for (int i = 0; i < 260; i++) term_v(i == 0, i == 259, 1);
    expect_frame(48'd260, 0, 48'd260, 0, 8'd255);
    idle(4);
    while (obs_rd < obs_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL count_sat stray got=%h want=no pulse", obs_mem[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin
          n_fail++;
          $display("FAIL count_sat got=%h want=%h", obs_mem[obs_rd], e);
        end
      end
      obs_rd++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL count_sat missing got=0 want=%0d more pulses", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_abandon;
    pulse_t e;
    int     wr_before;
    wr_before = obs_wr;
    term_v(1, 0, 5);
    term_v(0, 1, 6);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    n_checks++;
    if ({rv0, r0, o0, c0, rv1, r1, o1, c1} !== 116'd0) begin
      n_fail++;
      $display("FAIL reset_midframe_outputs got=%h want=0", {rv0, r0, o0, c0, rv1, r1, o1, c1});
    end
    idle(3);
    n_checks++;
    if (obs_wr != wr_before) begin
      n_fail++;
      $display("FAIL reset_midframe_pulse got=%0d pulses want=0", obs_wr - wr_before);
    end
    obs_rd = obs_wr;
    // No in_first since reset: accumulates onto 0 and counts from 0.
    term_v(0, 1, 4);
    expect_frame(48'd4, 0, 48'd4, 0, 8'd1);
    // Open frame abandoned by a new in_first.
    term_v(1, 0, 5);
    term_v(0, 0, 6);
    term_v(1, 1, 9);
    expect_frame(48'd9, 0, 48'd9, 0, 8'd1);
    idle(4);
    while (obs_rd < obs_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL abandon stray got=%h want=no pulse", obs_mem[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin
          n_fail++;
          $display("FAIL abandon got=%h want=%h", obs_mem[obs_rd], e);
        end
      end
      obs_rd++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abandon missing got=0 want=%0d more pulses", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_single_and_sign;
    test_back_to_back;
    test_overflow;
    test_count_saturation;
    test_reset_abandon;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
